// File: rtl/mem_rsp_sram.sv
// Leaf memory responder: one transaction at a time, fixed access latency, byte-lane writes.
// Optional macro MEM_RSP_TRACE_EN prints one line per executed access.
module mem_rsp_sram #(
   parameter int                    DATA_WIDTH = 64,
   parameter int                    DEPTH_LOG2 = 12,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
   parameter int                    LATENCY    = 2
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  iReqValid,
   output logic                  oReqReady,
   input  logic                  iReqWrEn,
   input  logic [DATA_WIDTH-1:0] iReqAddr,
   input  logic [DATA_WIDTH-1:0] iReqWrData,
   input  logic [7:0]            iReqWrLen,
   output logic                  oRespValid,
   input  logic                  iRespReady,
   output logic [DATA_WIDTH-1:0] oRespData,
   output logic                  oRespErr
);

   localparam int NB = DATA_WIDTH / 8;
   localparam logic [DATA_WIDTH-1:0] SPAN = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (DEPTH_LOG2 + 3);

   typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  init_q;
   logic                  wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [7:0]            wr_len_q, wr_len_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  resp_err_q, resp_err_d;

   logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

   logic [DATA_WIDTH-1:0] offset, rd_word, wr_shift, mem_wdata;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic [2:0]            lane;
   logic                  in_range, len_ok, fits, wr_ok, mem_we;
   logic [15:0]           mask_wide;
   logic [NB-1:0]         byte_mask;

   // State register; init_q keeps ready low until the first edge after reset release
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         init_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         wr_len_q    <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_q      <= 1'b1;
         wr_en_q     <= wr_en_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         wr_len_q    <= wr_len_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // WAIT runs LATENCY+1 cycles so the response lands LATENCY+2 edges after accept
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_d   = wr_en_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      wr_len_d  = wr_len_q;
      case (state_q)
         IDLE: if (iReqValid && oReqReady) begin
            state_d   = WAIT;
            cnt_d     = 4'(LATENCY);
            wr_en_d   = iReqWrEn;
            addr_d    = iReqAddr;
            wr_data_d = iReqWrData;
            wr_len_d  = iReqWrLen;
         end
         WAIT: if (cnt_q == 4'd0) state_d = EXEC;
               else               cnt_d   = cnt_q - 4'd1;
         EXEC: state_d = RESP;
         RESP: if (iRespReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      oReqReady  = (state_q == IDLE) && init_q;
      oRespValid = (state_q == RESP);
      oRespData  = resp_data_q;
      oRespErr   = resp_err_q;
   end

   always_comb begin
      offset   = addr_q - BASE_ADDR;
      in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
      word_idx = offset[DEPTH_LOG2+2:3];
      lane     = addr_q[2:0];
      rd_word  = mem_q[word_idx];
      case (wr_len_q)
         8'd1, 8'd2, 8'd4, 8'd8: len_ok = 1'b1;
         default:                len_ok = 1'b0;
      endcase
      fits      = (9'(lane) + 9'(wr_len_q)) <= 9'd8;
      wr_ok     = len_ok && fits;
      mask_wide = ((16'd1 << wr_len_q[3:0]) - 16'd1) << lane;
      byte_mask = wr_ok ? mask_wide[NB-1:0] : '0;
      wr_shift  = wr_data_q << {lane, 3'b000};
      for (int b = 0; b < NB; b++)
         mem_wdata[b*8 +: 8] = byte_mask[b] ? wr_shift[b*8 +: 8] : rd_word[b*8 +: 8];
      mem_we = (state_q == EXEC) && wr_en_q && in_range && wr_ok;

      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      if (state_q == EXEC) begin
         resp_data_d = (!wr_en_q && in_range) ? rd_word : '0;
         resp_err_d  = !in_range || (wr_en_q && !wr_ok);
      end else if (state_q == RESP && iRespReady) begin
         resp_data_d = '0;
         resp_err_d  = 1'b0;
      end
   end

   // Array contents survive reset; async reset already forces state away from EXEC
   always_ff @(posedge iClock) begin
      if (mem_we) mem_q[word_idx] <= mem_wdata;
   end

`ifdef MEM_RSP_TRACE_EN
   always @(posedge iClock) begin
      if (!iReset && state_q == EXEC)
         $display("[mem] %s addr=%h data=%h len=%d err=%b", wr_en_q ? "W" : "R", addr_q,
                  wr_en_q ? wr_data_q : resp_data_d, wr_len_q, resp_err_d);
   end
`else
   // No trace output in the default build.
`endif

endmodule
